// File: rtl/cost_vector_packer_pkg.sv
// cost_vector_packer_pkg: state encoding and sizing helper shared by the cost vector packer.
package cost_vector_packer_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/cost_vector_packer.sv
// cost_vector_packer: gathers serial cost words into a padded packed vector for argmin,
// double buffered so one vector collects while the previous waits downstream.
module cost_vector_packer
   import cost_vector_packer_pkg::*;
#(
   parameter int WIDTH     = 7,
   parameter int INPUTS    = 8,
   parameter int CNT_WIDTH = clog2(INPUTS + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        in_word,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic [WIDTH*INPUTS-1:0] out_words,
   output logic [CNT_WIDTH-1:0]    out_count,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int               IW       = clog2(INPUTS);
   localparam logic [WIDTH-1:0] PAD      = '1;
   localparam logic [IW-1:0]    LAST_IDX = IW'(INPUTS - 1);

   state_e                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [WIDTH*INPUTS-1:0] coll_q, coll_d, fill, out_words_q, out_words_d;
   logic [CNT_WIDTH-1:0]    hold_cnt_q, hold_cnt_d, out_count_q, out_count_d, cnt;
   logic                    out_valid_q, out_valid_d, out_fire, closing;

   // Collect register with this cycle's word merged in and all later slots padded.
   for (genvar k = 0; k < INPUTS; k++) begin : g_slot
      assign fill[k*WIDTH +: WIDTH] = (IW'(k) < idx_q)  ? coll_q[k*WIDTH +: WIDTH] :
                                      (IW'(k) == idx_q) ? in_word : PAD;
   end

   assign out_fire = out_valid_q && out_ready;
   assign closing  = in_last || (idx_q == LAST_IDX);
   assign cnt      = CNT_WIDTH'(idx_q + 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= COLLECT;
         idx_q       <= '0;
         coll_q      <= '0;
         hold_cnt_q  <= '0;
         out_words_q <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         coll_q      <= coll_d;
         hold_cnt_q  <= hold_cnt_d;
         out_words_q <= out_words_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      coll_d      = coll_q;
      hold_cnt_d  = hold_cnt_q;
      out_words_d = out_words_q;
      out_count_d = out_count_q;
      out_valid_d = out_valid_q && !out_ready;
      if (state_q == HOLD) begin
         if (out_fire) begin
            state_d     = COLLECT;
            idx_d       = '0;
            out_words_d = coll_q;
            out_count_d = hold_cnt_q;
            out_valid_d = 1'b1;
         end
      end else if (in_valid) begin
         coll_d = fill;
         idx_d  = closing ? '0 : IW'(idx_q + 1);
         if (closing && (!out_valid_q || out_ready)) begin
            out_words_d = fill;
            out_count_d = cnt;
            out_valid_d = 1'b1;
         end else if (closing) begin
            state_d    = HOLD;
            hold_cnt_d = cnt;
         end
      end
   end

   always_comb begin
      in_ready  = (state_q == COLLECT);
      out_words = out_words_q;
      out_count = out_count_q;
      out_valid = out_valid_q;
   end

endmodule

// File: tb/tb_cost_vector_packer.sv
// tb_cost_vector_packer: directed vector table, hold and reset sequences, then a throttled
// random run scored against a reference of the packed vector.
module tb_cost_vector_packer;

   typedef logic [7:0][6:0] vec_w;
   typedef struct { vec_w w; int n; vec_w e; int c; int ai; int av; } vec_t;
   typedef struct { vec_w w; logic [3:0] c; logic [10:0] a; } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] in_word = '0;
   logic       in_valid = 1'b0, in_last = 1'b0, in_ready, out_valid, out_ready;
   logic [55:0] out_words;
   logic [3:0]  out_count;
   int   n_chk = 0, n_fail = 0, n_sent = 0, n_deliv = 0;
   logic rdy_fixed = 1'b1, rdy_rand = 1'b0, lat_chk = 1'b0, gap_mode = 1'b0;
   exp_t exp_q[$];
   vec_t tbl[8];

   cost_vector_packer #(.WIDTH(7), .INPUTS(8)) dut (
      .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_words(out_words), .out_count(out_count),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   initial forever #5 clk = ~clk;

   function automatic vec_w mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
      vec_w v;
      v[0] = 7'(a0); v[1] = 7'(a1); v[2] = 7'(a2); v[3] = 7'(a3);
      v[4] = 7'(a4); v[5] = 7'(a5); v[6] = 7'(a6); v[7] = 7'(a7);
      return v;
   endfunction

   function automatic logic [10:0] amin(input vec_w v);
      int b = 0;
      for (int k = 1; k < 8; k++) if (v[k] < v[b]) b = k;
      return {4'(b), v[b]};
   endfunction

   function automatic void push(input vec_w e, input int c, input logic [10:0] a);
      exp_q.push_back('{e, 4'(c), a});
      n_sent++;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_word(input logic [6:0] w, input logic l, input logic closes, output int stalls);
      stalls   = 0;
      in_word  = w;
      in_last  = l;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready) begin
         stalls++;
         if (stalls > 500) begin
            n_fail++;
            $display("FAIL in_ready_timeout: stuck low for %0d cycles, expected release", stalls);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $fatal(1, "in_ready timeout");
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      if (closes && lat_chk) check("latency_out_valid", out_valid, 1);
   endtask

   task automatic send_vec(input vec_w w, input int n, input logic last8, output int stalls);
      int s;
      stalls = 0;
      for (int k = 0; k < n; k++) begin
         send_word(w[k], (k == n - 1) && (n < 8 || last8), k == n - 1, s);
         stalls += s;
         if (gap_mode && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_word  = 7'($urandom_range(0, 127));
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      out_ready = rdy_fixed;
      forever begin
         @(posedge clk);
         #2 out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
      end
   end

   // Scoreboard: pops one expected vector per output transfer and checks held outputs stay put.
   initial begin
      logic       hv;
      vec_w       hw;
      logic [3:0] hc;
      exp_t       e;
      hv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) hv = 1'b0;
         else begin
            if (hv) begin
               check("stable_words", out_words, hw);
               check("stable_count", out_count, hc);
               check("stable_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check("unexpected_vector", out_valid, 0);
               else begin
                  e = exp_q.pop_front();
                  n_deliv++;
                  check("words", out_words, e.w);
                  check("count", out_count, e.c);
                  check("argmin", amin(out_words), e.a);
               end
            end
            hv = out_valid && !out_ready;
            hw = out_words;
            hc = out_count;
         end
      end
   end

   initial begin
      int s;
      tbl[0] = '{mk(1, 2, 3, 4, 5, 6, 7, 8), 8, mk(1, 2, 3, 4, 5, 6, 7, 8), 8, 0, 1};
      tbl[1] = '{mk(13, 5, 19, 100, 0, 1, 1, 127), 8, mk(13, 5, 19, 100, 0, 1, 1, 127), 8, 4, 0};
      tbl[2] = '{mk(127, 55, 8, 100, 99, 12, 100, 3), 8, mk(127, 55, 8, 100, 99, 12, 100, 3), 8, 7, 3};
      tbl[3] = '{mk(20, 10, 30, 0, 0, 0, 0, 0), 3, mk(20, 10, 30, 127, 127, 127, 127, 127), 3, 1, 10};
      tbl[4] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), 1, mk(0, 127, 127, 127, 127, 127, 127, 127), 1, 0, 0};
      tbl[5] = '{mk(9, 8, 7, 6, 5, 4, 3, 0), 7, mk(9, 8, 7, 6, 5, 4, 3, 127), 7, 6, 3};
      tbl[6] = '{mk(127, 127, 127, 127, 127, 127, 127, 127), 8,
                 mk(127, 127, 127, 127, 127, 127, 127, 127), 8, 0, 127};
      tbl[7] = '{mk(50, 40, 40, 60, 70, 80, 90, 100), 8, mk(50, 40, 40, 60, 70, 80, 90, 100), 8, 1, 40};

      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_words", out_words, 0);
      check("rst_out_count", out_count, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Single vector: out_valid right after the closing edge, for exactly one cycle.
      lat_chk = 1'b1;
      push(tbl[0].e, tbl[0].c, {4'(tbl[0].ai), 7'(tbl[0].av)});
      send_vec(tbl[0].w, tbl[0].n, 1'b1, s);
      in_valid = 1'b0;
      check("stalls_v0", s, 0);
      @(negedge clk);
      @(negedge clk);
      check("pulse_once", out_valid, 0);
      @(posedge clk);
      #1;
      for (int i = 1; i < 8; i++) begin
         push(tbl[i].e, tbl[i].c, {4'(tbl[i].ai), 7'(tbl[i].av)});
         send_vec(tbl[i].w, tbl[i].n, 1'b1, s);
         check($sformatf("stalls_v%0d", i), s, 0);
      end
      in_valid = 1'b0;
      lat_chk  = 1'b0;
      drain();

      // Downstream stalled: second vector parks in the collect register.
      rdy_fixed = 1'b0;
      @(posedge clk);
      #1;
      push(tbl[0].e, 8, {4'(0), 7'(1)});
      push(tbl[2].e, 8, {4'(7), 7'(3)});
      send_vec(tbl[0].w, 8, 1'b1, s);
      check("hold_stalls_a", s, 0);
      send_vec(tbl[2].w, 8, 1'b1, s);
      check("hold_stalls_b", s, 0);
      in_valid = 1'b0;
      check("hold_in_ready", in_ready, 0);
      check("hold_front", out_words, tbl[0].e);
      repeat (4) @(posedge clk);
      #1 rdy_fixed = 1'b1;
      @(negedge clk);
      check("hold_still_blocked", in_ready, 0);
      check("hold_first", out_words, tbl[0].e);
      @(posedge clk);
      #1;
      check("hold_second", out_words, tbl[2].e);
      check("hold_second_valid", out_valid, 1);
      check("hold_released", in_ready, 1);
      drain();

      // Reset with a vector waiting on the output and a partial vector collecting.
      rdy_fixed = 1'b0;
      @(posedge clk);
      #1;
      send_vec(tbl[1].w, 8, 1'b1, s);
      for (int k = 0; k < 5; k++) send_word(7'(k + 1), 1'b0, 1'b0, s);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_words", out_words, 0);
      check("midrst_out_count", out_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_fixed = 1'b1;
      check("postrst_in_ready", in_ready, 1);
      push(mk(70, 60, 50, 40, 30, 20, 10, 5), 8, {4'(7), 7'(5)});
      send_vec(mk(70, 60, 50, 40, 30, 20, 10, 5), 8, 1'b1, s);
      push(mk(70, 60, 127, 127, 127, 127, 127, 127), 2, {4'(1), 7'(60)});
      send_vec(mk(70, 60, 0, 0, 0, 0, 0, 0), 2, 1'b1, s);
      in_valid = 1'b0;
      drain();

      rdy_rand = 1'b1;
      gap_mode = 1'b1;
      for (int v = 0; v < 1000; v++) begin
         vec_w w, e;
         int   n;
         logic l8;
         n  = $urandom_range(1, 8);
         l8 = 1'($urandom_range(0, 1));
         for (int k = 0; k < 8; k++) begin
            w[k] = 7'($urandom_range(0, 127));
            e[k] = (k < n) ? w[k] : 7'h7f;
         end
         push(e, n, amin(e));
         send_vec(w, n, l8, s);
      end
      in_valid = 1'b0;
      gap_mode = 1'b0;
      rdy_rand = 1'b0;
      drain();
      check("delivered_count", n_deliv, n_sent);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
